// File: rtl/ex_hazard_ctrl.sv
//------------------------------------------------------------------------------
// ex_hazard_ctrl
//
// Hazard and sequencing controller for the execute stage of a 5-stage RV32I
// pipeline. Generates operand forwarding selects, load-use stalls and
// taken-branch flushes. Holds IF/ID/EX while a multi-cycle EX unit (mul/div)
// is working. If the unit never reports completion, a timeout aborts the
// operation.
//
// Parameters
//   MC_TIMEOUT  maximum number of MC_WAIT cycles before abort (>= 2)
//
// Ports
//   clk          pipeline clock, rising edge
//   rst          asynchronous, active-high reset
//   rs1D, rs2D   source registers of the instruction in Decode
//   rs1E, rs2E   source registers of the instruction in Execute
//   rdE          destination register in Execute
//   resultsrcE   Execute instruction is a load
//   pcsrcE       taken branch/jump resolved in Execute
//   rdM          destination register in Memory
//   regwriteM    Memory instruction writes rdM
//   rdW          destination register in Writeback
//   regwriteW    Writeback instruction writes rdW
//   mc_startE    Execute instruction is a multi-cycle op (level)
//   mc_done      multi-cycle unit result is valid this cycle
//   fwdAE        srcA select: 00 RF, 01 W result, 10 M aluresult
//   fwdBE        srcB (pre-immediate mux) select, same encoding
//   stallF       hold PC
//   stallD       hold IF/ID register
//   stallE       hold ID/EX register
//   flushD       clear IF/ID register
//   flushE       clear ID/EX register (inject bubble)
//   mc_abort     one-cycle pulse that kills the multi-cycle unit
//   mc_timeout   sticky error flag, cleared only by rst
//------------------------------------------------------------------------------
module ex_hazard_ctrl #(
   parameter int unsigned MC_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] rs1D,
   input  logic [4:0] rs2D,
   input  logic [4:0] rs1E,
   input  logic [4:0] rs2E,
   input  logic [4:0] rdE,
   input  logic       resultsrcE,
   input  logic       pcsrcE,
   input  logic [4:0] rdM,
   input  logic       regwriteM,
   input  logic [4:0] rdW,
   input  logic       regwriteW,
   input  logic       mc_startE,
   input  logic       mc_done,
   output logic [1:0] fwdAE,
   output logic [1:0] fwdBE,
   output logic       stallF,
   output logic       stallD,
   output logic       stallE,
   output logic       flushD,
   output logic       flushE,
   output logic       mc_abort,
   output logic       mc_timeout
);

   localparam int unsigned CNT_W = $clog2(MC_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

   typedef enum logic {
      IDLE    = 1'b0,
      MC_WAIT = 1'b1
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             mc_timeout_q;

   logic in_idle;
   logic in_wait;
   logic lwstall;
   logic mc_go;
   logic abort;
   logic busy;

   // Memory stage is younger than Writeback, so its value wins when both
   // match. x0 is never forwarded: it reads as zero regardless of writes.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic       wr_m,
      input logic [4:0] rd_m,
      input logic       wr_w,
      input logic [4:0] rd_w
   );
      if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
         return 2'b10;
      end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
         return 2'b01;
      end else begin
         return 2'b00;
      end
   endfunction

   //---------------------------------------------------------------------------
   // Hazard conditions
   //---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here is assigned on every path, so no latch
      // can be inferred.
      in_idle = (state_q == IDLE);
      in_wait = (state_q == MC_WAIT);

      lwstall = resultsrcE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));

      // A taken branch kills the instruction in EX, so a multi-cycle op is not
      // started in the same cycle.
      mc_go = in_idle && mc_startE && !pcsrcE;

      abort = in_wait && !mc_done && (cnt_q == CNT_LAST);

      // In the completion cycle and in the abort cycle the stalls drop so EX
      // advances on that edge.
      busy = mc_go || (in_wait && !mc_done && !abort);
   end

   //---------------------------------------------------------------------------
   // Outputs: everything is forced low while reset is asserted, including the
   // purely combinational forwarding selects.
   //---------------------------------------------------------------------------
   always_comb begin
      fwdAE      = 2'b00;
      fwdBE      = 2'b00;
      stallF     = 1'b0;
      stallD     = 1'b0;
      stallE     = 1'b0;
      flushD     = 1'b0;
      flushE     = 1'b0;
      mc_abort   = 1'b0;
      mc_timeout = 1'b0;
      if (!rst) begin
         fwdAE      = fwd_sel(rs1E, regwriteM, rdM, regwriteW, rdW);
         fwdBE      = fwd_sel(rs2E, regwriteM, rdM, regwriteW, rdW);
         stallF     = busy || lwstall;
         stallD     = busy || lwstall;
         stallE     = busy;
         flushD     = in_idle && pcsrcE;
         // A load-use bubble is only injected when EX is not being held; while
         // an MC op is in flight the stalls already freeze Decode.
         flushE     = (in_idle && (pcsrcE || (lwstall && !busy))) || abort;
         mc_abort   = abort;
         mc_timeout = mc_timeout_q;
      end
   end

   //---------------------------------------------------------------------------
   // Multi-cycle sequencing FSM. cnt_q counts cycles spent in MC_WAIT.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         mc_timeout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // mc_done is ignored here: no op is outstanding.
               if (mc_go) begin
                  state_q <= MC_WAIT;
                  cnt_q   <= '0;
               end
            end
            MC_WAIT: begin
               if (mc_done) begin
                  state_q <= IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  state_q      <= IDLE;
                  mc_timeout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
//------------------------------------------------------------------------------
// tb_ex_hazard_ctrl
//
// Directed bench for ex_hazard_ctrl with MC_TIMEOUT = 8. Single-cycle
// behaviour is covered by a table of {inputs, expected outputs} records; the
// multi-cycle op, timeout and mid-operation reset are hand-written sequences.
// Outputs are compared as one packed word:
//   {fwdAE, fwdBE, stallF, stallD, stallE, flushD, flushE, mc_abort, mc_timeout}
//------------------------------------------------------------------------------
module tb_ex_hazard_ctrl;

   localparam int unsigned MC_TIMEOUT = 8;

   logic       clk;
   logic       rst;
   logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic       resultsrcE, pcsrcE, regwriteM, regwriteW, mc_startE, mc_done;
   logic [1:0] fwdAE, fwdBE;
   logic       stallF, stallD, stallE, flushD, flushE, mc_abort, mc_timeout;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE;
      logic        resultsrcE, pcsrcE;
      logic [4:0]  rdM;
      logic        regwriteM;
      logic [4:0]  rdW;
      logic        regwriteW, mc_startE, mc_done;
      logic [10:0] exp;
   } vec_t;

   vec_t vq[$];

   ex_hazard_ctrl #(.MC_TIMEOUT(MC_TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .rs1D       (rs1D),
      .rs2D       (rs2D),
      .rs1E       (rs1E),
      .rs2E       (rs2E),
      .rdE        (rdE),
      .resultsrcE (resultsrcE),
      .pcsrcE     (pcsrcE),
      .rdM        (rdM),
      .regwriteM  (regwriteM),
      .rdW        (rdW),
      .regwriteW  (regwriteW),
      .mc_startE  (mc_startE),
      .mc_done    (mc_done),
      .fwdAE      (fwdAE),
      .fwdBE      (fwdBE),
      .stallF     (stallF),
      .stallD     (stallD),
      .stallE     (stallE),
      .flushD     (flushD),
      .flushE     (flushE),
      .mc_abort   (mc_abort),
      .mc_timeout (mc_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [10:0] outs();
      return {fwdAE, fwdBE, stallF, stallD, stallE, flushD, flushE, mc_abort, mc_timeout};
   endfunction

   task automatic check(input string name, input logic [10:0] exp);
      logic [10:0] act;
      act = outs();
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b_%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b_%b", name,
                  act[10:9], act[8:7], act[6:4], act[3:2], act[1], act[0],
                  exp[10:9], exp[8:7], exp[6:4], exp[3:2], exp[1], exp[0]);
      end
   endtask

   task automatic clear_inputs();
      rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0;
      resultsrcE = 1'b0; pcsrcE = 1'b0;
      rdM = '0; regwriteM = 1'b0; rdW = '0; regwriteW = 1'b0;
      mc_startE = 1'b0; mc_done = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      rs1D = v.rs1D; rs2D = v.rs2D; rs1E = v.rs1E; rs2E = v.rs2E; rdE = v.rdE;
      resultsrcE = v.resultsrcE; pcsrcE = v.pcsrcE;
      rdM = v.rdM; regwriteM = v.regwriteM; rdW = v.rdW; regwriteW = v.regwriteW;
      mc_startE = v.mc_startE; mc_done = v.mc_done;
   endtask

   task automatic add_vec(
      input logic [4:0] a_rs1D, input logic [4:0] a_rs2D,
      input logic [4:0] a_rs1E, input logic [4:0] a_rs2E, input logic [4:0] a_rdE,
      input logic a_ld, input logic a_br,
      input logic [4:0] a_rdM, input logic a_wm,
      input logic [4:0] a_rdW, input logic a_ww,
      input logic a_start, input logic a_done,
      input logic [10:0] a_exp
   );
      vec_t v;
      v.rs1D = a_rs1D; v.rs2D = a_rs2D; v.rs1E = a_rs1E; v.rs2E = a_rs2E; v.rdE = a_rdE;
      v.resultsrcE = a_ld; v.pcsrcE = a_br;
      v.rdM = a_rdM; v.regwriteM = a_wm; v.rdW = a_rdW; v.regwriteW = a_ww;
      v.mc_startE = a_start; v.mc_done = a_done;
      v.exp = a_exp;
      vq.push_back(v);
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled 3
   // units later, well clear of both edges.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // MC op with mc_done four cycles after start. Cycle 2 also raises a branch
   // and a load-use hazard, which must not flush while the op is in flight.
   // Cycle 5 probes IDLE through the branch flush.
   task automatic run_mc_op(input string tag);
      for (int c = 0; c <= 6; c++) begin
         clear_inputs();
         case (c)
            0, 1, 3: mc_startE = 1'b1;
            2: begin
               mc_startE = 1'b1; pcsrcE = 1'b1;
               resultsrcE = 1'b1; rdE = 5'd7; rs1D = 5'd7;
            end
            4: begin mc_startE = 1'b1; mc_done = 1'b1; end
            5: pcsrcE = 1'b1;
            default: ;
         endcase
         #3;
         case (c)
            0, 1, 2, 3: check($sformatf("%s_c%0d", tag, c), 11'b00_00_111_00_0_0);
            5:          check($sformatf("%s_c%0d", tag, c), 11'b00_00_000_11_0_0);
            default:    check($sformatf("%s_c%0d", tag, c), 11'b00_00_000_00_0_0);
         endcase
         next_cycle();
      end
   endtask

   initial begin
      // Expected word layout: fwdA_fwdB_stallFDE_flushDE_abort_timeout
      //       rs1D  rs2D  rs1E  rs2E  rdE  ld    br    rdM  wM    rdW  wW    st    dn
      add_vec(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 11'b00_00_000_00_0_0);
      add_vec(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 11'b10_00_000_00_0_0);
      add_vec(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 11'b01_00_000_00_0_0);
      add_vec(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 11'b00_00_000_00_0_0);
      add_vec(5'd0, 5'd0, 5'd9, 5'd3, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 11'b01_10_000_00_0_0);
      add_vec(5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 11'b00_01_000_00_0_0);
      add_vec(5'd0, 5'd0, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 11'b00_00_000_00_0_0);
      add_vec(5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 11'b00_00_110_01_0_0);
      add_vec(5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 11'b00_00_110_01_0_0);
      add_vec(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 11'b00_00_000_00_0_0);
      add_vec(5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 11'b00_00_000_00_0_0);
      add_vec(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 11'b00_00_000_11_0_0);
      add_vec(5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 11'b00_00_110_11_0_0);
      add_vec(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 11'b00_00_000_00_0_0);

      // Reset: all outputs low even with hazard-producing inputs present.
      clear_inputs();
      rst = 1'b1;
      regwriteM = 1'b1; rdM = 5'd5; rs1E = 5'd5;
      resultsrcE = 1'b1; rdE = 5'd7; rs2D = 5'd7; pcsrcE = 1'b1;
      #2;
      check("reset_outputs", 11'b00_00_000_00_0_0);
      @(posedge clk);
      @(negedge clk);
      clear_inputs();
      rst = 1'b0;
      next_cycle();

      // Single-cycle table (branch+mc_startE vector must leave the FSM in IDLE,
      // which the following vectors confirm).
      foreach (vq[i]) begin
         apply(vq[i]);
         #3;
         check($sformatf("vec%0d", i), vq[i].exp);
         next_cycle();
      end

      // Multi-cycle op completing normally.
      run_mc_op("mc_op");

      // Asynchronous reset in the middle of MC_WAIT.
      clear_inputs();
      mc_startE = 1'b1;
      #3; check("rst_mid_c0", 11'b00_00_111_00_0_0);
      next_cycle();
      #3; check("rst_mid_c1", 11'b00_00_111_00_0_0);
      next_cycle();
      regwriteM = 1'b1; rdM = 5'd5; rs1E = 5'd5;
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid_async", 11'b00_00_000_00_0_0);
      next_cycle();
      #2;
      check("rst_mid_held", 11'b00_00_000_00_0_0);
      clear_inputs();
      rst = 1'b0;
      #1;
      check("rst_mid_released", 11'b00_00_000_00_0_0);
      next_cycle();
      run_mc_op("mc_after_rst");

      // Timeout: mc_done never arrives.
      clear_inputs();
      mc_startE = 1'b1;
      for (int c = 0; c < 8; c++) begin
         #3;
         check($sformatf("to_stall_c%0d", c), 11'b00_00_111_00_0_0);
         next_cycle();
      end
      #3;
      check("to_abort", 11'b00_00_000_01_1_0);
      next_cycle();
      clear_inputs();
      for (int c = 0; c < 3; c++) begin
         pcsrcE = (c == 2);
         #3;
         if (c == 2) check("to_sticky_idle_branch", 11'b00_00_000_11_0_1);
         else        check($sformatf("to_sticky_c%0d", c), 11'b00_00_000_00_0_1);
         next_cycle();
      end
      clear_inputs();
      rst = 1'b1;
      #1;
      check("to_cleared_by_rst", 11'b00_00_000_00_0_0);
      next_cycle();
      rst = 1'b0;
      #3;
      check("to_after_rst", 11'b00_00_000_00_0_0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
